period_meter: RTL and testbench

- Measures an external slow square wave, such as a divided clock or a board signal, against the system clock.
- Reports period and high time in clk cycles, plus a log2 divider estimate: the frqdiv value that would regenerate the wave as bit frqdiv of a free-running counter.
- Sits on the input side of lab designs: self-checking of divided clocks, tachometer/button-rate measurement, 7-seg display feeds.

---
 rtl/period_meter_pkg.sv | 25 ++
 rtl/period_meter_sync_edge.sv | 40 ++++
 rtl/period_meter.sv | 170 +++++++++++++++++
 tb/tb_period_meter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared types and helpers for the period meter.
//   pm_state_t   - measurement FSM state encoding
//   CNT_W_DEF    - default counter/output width
//   DIV_W        - width of the log2 divider estimate
//   lead_one_m1  - floor(log2(v)) - 1, or 0 when v < 2
package period_meter_pkg;

  typedef enum logic [1:0] {IDLE, ARM, MEASURE} pm_state_t;

  localparam int CNT_W_DEF = 31;
  localparam int DIV_W     = 5;
  localparam int LO_W      = 32;

  // Priority encoder on the leading one; callers zero-extend to LO_W bits.
  function automatic logic [DIV_W-1:0] lead_one_m1(input logic [LO_W-1:0] v);
    int unsigned pos;
    pos = 0;
    for (int unsigned i = 0; i < LO_W; i++) begin
      if (v[i[4:0]]) pos = i;
    end
    if (pos == 0) return '0;
    return DIV_W'(pos - 1);
  endfunction

endpackage

// File: rtl/period_meter_sync_edge.sv
// sync_edge: multi-stage synchronizer for an asynchronous input followed by
// one extra flop for edge detection. Reusable for button inputs.
//   clk, rst_n - clock, asynchronous active-low reset
//   d          - asynchronous input
//   level      - synchronized level
//   rise/fall  - single-cycle pulses on synchronized rising/falling edges
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d};
    dly_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~dly_q;
  assign fall  = ~level & dly_q;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow external square wave
// in clk cycles and derives a log2 divider estimate.
//   clk, rst_n  - system clock, asynchronous active-low reset
//   en          - measurement enable
//   in_sig      - asynchronous signal under test
//   period      - last measured period (clk cycles)
//   high_time   - last measured high time (0 unless PERIOD_METER_HIGH_EN)
//   div_est     - floor(log2(period)) - 1, or 0 if period < 2
//   meas_valid  - one-cycle pulse when the results update
//   locked      - a valid measurement since arming, no timeout since
//   timeout     - sticky: no rising edge within 2^TIMEOUT_LOG2-1 cycles
// Build option: define PERIOD_METER_HIGH_EN to include high-time measurement.
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W        = CNT_W_DEF,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT_LOG2 = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_sig,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic [DIV_W-1:0] div_est,
  output logic             meas_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'((64'd1 << TIMEOUT_LOG2) - 64'd1);

  logic sig_level, sig_rise, sig_fall;
  logic unused_ok;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (in_sig),
    .level (sig_level),
    .rise  (sig_rise),
    .fall  (sig_fall)
  );

  pm_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_p_q, cnt_p_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             mv_q, mv_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;
`ifdef PERIOD_METER_HIGH_EN
  logic [CNT_W-1:0] cnt_h_q, cnt_h_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             hi_done_q, hi_done_d;
  assign unused_ok = sig_level;
`else
  assign unused_ok = sig_level ^ sig_fall;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_p_d   = cnt_p_q;
    period_d  = period_q;
    div_d     = div_q;
    mv_d      = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;
`ifdef PERIOD_METER_HIGH_EN
    cnt_h_d   = cnt_h_q;
    high_d    = high_q;
    hi_done_d = hi_done_q;
`endif
    case (state_q)
      IDLE: begin
        locked_d  = 1'b0;
        timeout_d = 1'b0;
        if (en) state_d = ARM;
      end
      ARM: begin
        if (!en) begin
          state_d   = IDLE;
          locked_d  = 1'b0;
          timeout_d = 1'b0;
        end else if (sig_rise) begin
          cnt_p_d   = CNT_W'(1);
`ifdef PERIOD_METER_HIGH_EN
          cnt_h_d   = CNT_W'(1);
          hi_done_d = 1'b0;
`endif
          state_d   = MEASURE;
        end
      end
      MEASURE: begin
        // en-fall has priority over a coincident rise: the result is dropped.
        if (!en) begin
          state_d   = IDLE;
          locked_d  = 1'b0;
          timeout_d = 1'b0;
        end else if (sig_rise) begin
          period_d  = cnt_p_q;
          div_d     = lead_one_m1(LO_W'(cnt_p_q));
          mv_d      = 1'b1;
          locked_d  = 1'b1;
          timeout_d = 1'b0;
          cnt_p_d   = CNT_W'(1);
`ifdef PERIOD_METER_HIGH_EN
          high_d    = cnt_h_q;
          cnt_h_d   = CNT_W'(1);
          hi_done_d = 1'b0;
`endif
        end else if (cnt_p_q == TO_LIMIT) begin
          timeout_d = 1'b1;
          locked_d  = 1'b0;
          state_d   = ARM;
        end else begin
          cnt_p_d = cnt_p_q + CNT_W'(1);
`ifdef PERIOD_METER_HIGH_EN
          if (sig_fall) hi_done_d = 1'b1;
          else if (!hi_done_q) cnt_h_d = cnt_h_q + CNT_W'(1);
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_p_q   <= '0;
      period_q  <= '0;
      div_q     <= '0;
      mv_q      <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef PERIOD_METER_HIGH_EN
      cnt_h_q   <= '0;
      high_q    <= '0;
      hi_done_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_p_q   <= cnt_p_d;
      period_q  <= period_d;
      div_q     <= div_d;
      mv_q      <= mv_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
`ifdef PERIOD_METER_HIGH_EN
      cnt_h_q   <= cnt_h_d;
      high_q    <= high_d;
      hi_done_q <= hi_done_d;
`endif
    end
  end

  assign period     = period_q;
  assign div_est    = div_q;
  assign meas_valid = mv_q;
  assign locked     = locked_q;
  assign timeout    = timeout_q;
`ifdef PERIOD_METER_HIGH_EN
  assign high_time  = high_q;
`else
  assign high_time  = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed self-checking bench for period_meter.
module tb_period_meter;

  localparam int CNT_W = 31;
`ifdef PERIOD_METER_HIGH_EN
  localparam bit HIGH_EN = 1'b1;
`else
  localparam bit HIGH_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             in_sig = 1'b0;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic [4:0]       div_est;
  logic             meas_valid;
  logic             locked;
  logic             timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ph      = 0;
  int hi_len  = 1;
  int per_len = 2;
  bit wave_on = 1'b0;

  period_meter #(.CNT_W(CNT_W), .SYNC_STAGES(2), .TIMEOUT_LOG2(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .in_sig     (in_sig),
    .period     (period),
    .high_time  (high_time),
    .div_est    (div_est),
    .meas_valid (meas_valid),
    .locked     (locked),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Advance one clock, then update the wave generator away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (wave_on) begin
      ph++;
      if (ph >= per_len) ph = 0;
      in_sig = (ph < hi_len);
    end
  endtask

  task automatic set_wave(input int hi, input int per);
    hi_len  = hi;
    per_len = per;
    ph      = 0;
    in_sig  = 1'b1;
    wave_on = 1'b1;
  endtask

  task automatic do_reset();
    wave_on = 1'b0;
    in_sig  = 1'b0;
    en      = 1'b0;
    rst_n   = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; in_sig = 1'b0;
    #2;
    n_tests++;
    if ({period, high_time, div_est, meas_valid, locked, timeout} !== '0)
      begin n_fail++; $display("FAIL reset_outputs: got p=%0d h=%0d d=%0d mv=%b l=%b t=%b required all 0",
                               period, high_time, div_est, meas_valid, locked, timeout); end
    en = 1'b1; in_sig = 1'b1;
    repeat (4) tick();
    n_tests++;
    if ({period, meas_valid, locked, timeout} !== '0)
      begin n_fail++; $display("FAIL reset_hold: got p=%0d mv=%b l=%b t=%b required all 0",
                               period, meas_valid, locked, timeout); end
  endtask

  task automatic test_wave(input string name, input int hi, input int per,
                           input int exp_p, input int exp_h, input int exp_d);
    int np, last, eh;
    eh = HIGH_EN ? exp_h : 0;
    np = 0; last = 0;
    do_reset();
    en = 1'b1;
    set_wave(hi, per);
    for (int i = 0; i < 12 * per + 20; i++) begin
      tick();
      if (meas_valid === 1'b1) begin
        np++;
        n_tests++;
        if (period !== CNT_W'(exp_p)) begin n_fail++;
          $display("FAIL %s_period: got %0d required %0d", name, period, exp_p); end
        n_tests++;
        if (high_time !== CNT_W'(eh)) begin n_fail++;
          $display("FAIL %s_high: got %0d required %0d", name, high_time, eh); end
        n_tests++;
        if (div_est !== 5'(exp_d)) begin n_fail++;
          $display("FAIL %s_div: got %0d required %0d", name, div_est, exp_d); end
        n_tests++;
        if (locked !== 1'b1) begin n_fail++;
          $display("FAIL %s_locked: got %b required 1", name, locked); end
        if (np > 1) begin
          n_tests++;
          if (cyc - last != per) begin n_fail++;
            $display("FAIL %s_interval: got %0d required %0d", name, cyc - last, per); end
        end
        last = cyc;
      end else if (np == 0) begin
        n_tests++;
        if (locked !== 1'b0) begin n_fail++;
          $display("FAIL %s_prelock: got %b required 0", name, locked); end
      end
    end
    n_tests++;
    if (np < 8) begin n_fail++;
      $display("FAIL %s_pulse_count: got %0d required >=8", name, np); end
  endtask

  task automatic test_timeout();
    int np, k, bad;
    bit got;
    do_reset();
    en = 1'b1;
    set_wave(8, 16);
    np = 0;
    for (int i = 0; i < 200 && np < 2; i++) begin
      tick();
      if (meas_valid === 1'b1) np++;
    end
    n_tests++;
    if (np < 2) begin n_fail++; $display("FAIL to_lock: got %0d pulses required 2", np); end
    wave_on = 1'b0;
    in_sig  = 1'b0;
    k = 0; got = 1'b0; bad = 0;
    while (k < 400 && !got) begin
      tick();
      k++;
      if (meas_valid === 1'b1) bad++;
      if (timeout === 1'b1) got = 1'b1;
    end
    n_tests++;
    if (!got || k != 255) begin n_fail++;
      $display("FAIL to_latency: got %0d (seen=%b) required 255", k, got); end
    n_tests++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL to_locked: got %b required 0", locked); end
    n_tests++;
    if (period !== CNT_W'(16)) begin n_fail++; $display("FAIL to_period_hold: got %0d required 16", period); end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL to_spurious_mv: got %0d required 0", bad); end
    repeat (5) tick();
    n_tests++;
    if (timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky: got %b required 1", timeout); end
    set_wave(8, 16);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      if (meas_valid === 1'b1) got = 1'b1;
    end
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL to_resume_mv: got 0 required 1"); end
    n_tests++;
    if (timeout !== 1'b0 || locked !== 1'b1) begin n_fail++;
      $display("FAIL to_resume_flags: got t=%b l=%b required t=0 l=1", timeout, locked); end
    n_tests++;
    if (period !== CNT_W'(16)) begin n_fail++; $display("FAIL to_resume_period: got %0d required 16", period); end
  endtask

  task automatic test_en_drop();
    int np, bad, k;
    bit got;
    do_reset();
    en = 1'b1;
    set_wave(8, 16);
    np = 0;
    for (int i = 0; i < 200 && np < 2; i++) begin
      tick();
      if (meas_valid === 1'b1) np++;
    end
    n_tests++;
    if (np < 2) begin n_fail++; $display("FAIL en_lock: got %0d pulses required 2", np); end
    repeat (5) tick();
    en = 1'b0;
    tick();
    n_tests++;
    if (locked !== 1'b0) begin n_fail++; $display("FAIL en_locked_drop: got %b required 0", locked); end
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (meas_valid === 1'b1) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL en_spurious_mv: got %0d required 0", bad); end
    n_tests++;
    if (period !== CNT_W'(16) || div_est !== 5'd3) begin n_fail++;
      $display("FAIL en_retain: got p=%0d d=%0d required p=16 d=3", period, div_est); end
    n_tests++;
    if (locked !== 1'b0 || timeout !== 1'b0) begin n_fail++;
      $display("FAIL en_idle_flags: got l=%b t=%b required 0 0", locked, timeout); end
    en = 1'b1;
    k = 0; got = 1'b0;
    while (k < 60 && !got) begin
      tick();
      k++;
      if (meas_valid === 1'b1) got = 1'b1;
    end
    n_tests++;
    if (!got || k < 18 || k > 33) begin n_fail++;
      $display("FAIL en_relock_latency: got %0d (seen=%b) required 18..33", k, got); end
    n_tests++;
    if (period !== CNT_W'(16) || locked !== 1'b1) begin n_fail++;
      $display("FAIL en_relock: got p=%0d l=%b required p=16 l=1", period, locked); end
  endtask

  task automatic test_reset_mid();
    int np;
    bit got;
    do_reset();
    en = 1'b1;
    set_wave(8, 16);
    np = 0;
    for (int i = 0; i < 200 && np < 2; i++) begin
      tick();
      if (meas_valid === 1'b1) np++;
    end
    n_tests++;
    if (np < 2 || locked !== 1'b1) begin n_fail++;
      $display("FAIL rst_mid_lock: got %0d pulses l=%b required 2 l=1", np, locked); end
    repeat (6) tick();
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({period, high_time, div_est, meas_valid, locked, timeout} !== '0)
      begin n_fail++; $display("FAIL rst_mid_async: got p=%0d h=%0d d=%0d mv=%b l=%b t=%b required all 0",
                               period, high_time, div_est, meas_valid, locked, timeout); end
    repeat (3) tick();
    rst_n = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick();
      if (meas_valid === 1'b1) got = 1'b1;
    end
    n_tests++;
    if (!got || period !== CNT_W'(16) || locked !== 1'b1) begin n_fail++;
      $display("FAIL rst_mid_relock: got seen=%b p=%0d l=%b required seen=1 p=16 l=1", got, period, locked); end
  endtask

  initial begin
    test_reset();
    test_wave("divclk", 8, 16, 16, 8, 3);
    test_wave("fast",   1, 2,  2,  1, 0);
    test_wave("asym",   3, 10, 10, 3, 2);
    test_timeout();
    test_en_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
